// File: rtl/cam_frame_scheduler.sv
// OV5640 capture sequencer: init hold-off, warm-up frame skip, one frame per cap_req.
// Define CAM_SCHED_CONT_EN for continuous capture (DONE re-arms without cap_req).
module cam_frame_scheduler #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int SKIP_FRAMES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cam_init_done,
   input  logic        vsync,
   input  logic        de,
   input  logic [15:0] data_in,
   input  logic        cap_req,
   output logic        busy,
   output logic        pix_valid,
   output logic [15:0] pix_data,
   output logic [10:0] pix_x,
   output logic [9:0]  pix_y,
   output logic        sof,
   output logic        eol,
   output logic        eof,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] frame_cnt
);

   typedef enum logic [2:0] {WAIT_INIT, SKIP, IDLE, ARM, CAPTURE, DONE} state_t;

   localparam logic [11:0] H_L       = 12'(H_ACTIVE);
   localparam logic [11:0] V_L       = 12'(V_ACTIVE);
   localparam logic [15:0] SKIP_LAST = 16'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

   state_t      state, state_nx;
   logic        vsync_d;
   logic        vs_rise;
   logic [11:0] x_cnt, y_cnt;
   logic        line_open;
   logic        err_flag;
   logic [15:0] skip_cnt;
   logic        rearm;

   assign vs_rise = vsync & ~vsync_d;

`ifdef CAM_SCHED_CONT_EN
   // The vs_rise that closed the previous frame is consumed here so ARM starts the next one at once.
   always_ff @(posedge clk) begin
      if (rst) rearm <= 1'b0;
      else     rearm <= (state == DONE);
   end
`else
   assign rearm = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         WAIT_INIT: if (cam_init_done) state_nx = SKIP;
         SKIP: begin
            if (SKIP_FRAMES == 0)                     state_nx = IDLE;
            else if (vs_rise && skip_cnt == SKIP_LAST) state_nx = IDLE;
         end
         IDLE:    if (cap_req) state_nx = ARM;
         ARM:     if (vs_rise || rearm) state_nx = CAPTURE;
         CAPTURE: if (vs_rise) state_nx = DONE;
`ifdef CAM_SCHED_CONT_EN
         DONE:    state_nx = ARM;
`else
         DONE:    state_nx = IDLE;
`endif
         default: state_nx = WAIT_INIT;
      endcase
      if (!cam_init_done) state_nx = WAIT_INIT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WAIT_INIT;
         vsync_d    <= 1'b0;
         busy       <= 1'b0;
         pix_valid  <= 1'b0;
         pix_data   <= '0;
         pix_x      <= '0;
         pix_y      <= '0;
         sof        <= 1'b0;
         eol        <= 1'b0;
         eof        <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         frame_cnt  <= '0;
         x_cnt      <= '0;
         y_cnt      <= '0;
         line_open  <= 1'b0;
         err_flag   <= 1'b0;
         skip_cnt   <= '0;
      end else begin
         state      <= state_nx;
         vsync_d    <= vsync;
         busy       <= (state_nx == ARM) || (state_nx == CAPTURE) || (state_nx == DONE);
         pix_valid  <= 1'b0;
         sof        <= 1'b0;
         eol        <= 1'b0;
         eof        <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         if (state == WAIT_INIT)
            skip_cnt <= '0;
         else if (state == SKIP && vs_rise)
            skip_cnt <= skip_cnt + 16'd1;

         if (state == ARM && state_nx == CAPTURE) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            line_open <= 1'b0;
            err_flag  <= 1'b0;
         end

         // vs_rise has priority over a coincident pixel; that pixel is neither forwarded nor counted.
         if (state == CAPTURE && cam_init_done) begin
            if (vs_rise) begin
               if (y_cnt != V_L) err_flag <= 1'b1;
            end else if (de) begin
               line_open <= 1'b1;
               if (x_cnt != 12'hFFF) x_cnt <= x_cnt + 12'd1;
               if (x_cnt < H_L && y_cnt < V_L) begin
                  pix_valid <= 1'b1;
                  pix_data  <= data_in;
                  pix_x     <= x_cnt[10:0];
                  pix_y     <= y_cnt[9:0];
                  sof       <= (x_cnt == 12'd0) && (y_cnt == 12'd0);
                  eol       <= (x_cnt == H_L - 12'd1);
                  eof       <= (x_cnt == H_L - 12'd1) && (y_cnt == V_L - 12'd1);
               end else begin
                  err_flag <= 1'b1;
               end
            end else if (line_open) begin
               line_open <= 1'b0;
               x_cnt     <= '0;
               if (y_cnt != 12'hFFF) y_cnt <= y_cnt + 12'd1;
               if (x_cnt != H_L) err_flag <= 1'b1;
            end
         end

         if (state == DONE) begin
            frame_done <= 1'b1;
            frame_err  <= err_flag;
            frame_cnt  <= frame_cnt + 16'd1;
         end
      end
   end

endmodule
